// File: rtl/division_restoring_core_if.sv
// Operand/result bundle between the complement stage, the restoring divider
// and the result/display stage.
interface division_restoring_core_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] first_nr;
  logic [WIDTH-1:0] second_nr;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, first_nr, second_nr,
    input  quotient, remainder, done, busy, div_by_zero, overflow
  );

  modport slave (
    input  start, first_nr, second_nr,
    output quotient, remainder, done, busy, div_by_zero, overflow
  );
endinterface

// File: rtl/division_restoring_core.sv
// Sequential signed restoring divider: truncating quotient, remainder signed
// like the dividend, with divide-by-zero and overflow flags.
//
// state | meaning
// IDLE  | waiting for start, operands captured on start
// LOAD  | signs/magnitudes resolved, divide-by-zero detected
// ITER  | one restoring step per cycle, WIDTH cycles
// FIX   | sign correction, outputs registered, done pulse
module division_restoring_core #(
  parameter int WIDTH = 4
) (
  input logic                       clk,
  input logic                       rst,
  division_restoring_core_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_abs_b;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_done;
  logic             r_busy;
  logic             r_div_by_zero;
  logic             r_overflow;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_last;

  // Negating the most negative value wraps to itself, which read unsigned is
  // exactly its magnitude 2^(WIDTH-1).
  assign w_abs_a = r_a[WIDTH-1] ? (~r_a + 1'b1) : r_a;
  assign w_abs_b = r_b[WIDTH-1] ? (~r_b + 1'b1) : r_b;

  assign w_shift = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_abs_b};
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_abs_b       <= '0;
      r_q           <= '0;
      r_rem         <= '0;
      r_cnt         <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_dz          <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.first_nr;
            r_b     <= bus.second_nr;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sign_q <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_sign_r <= r_a[WIDTH-1];
          r_abs_b  <= w_abs_b;
          if (r_b == '0) begin
            r_dz    <= 1'b1;
            r_state <= S_FIX;
          end else begin
            r_dz    <= 1'b0;
            r_rem   <= '0;
            r_q     <= w_abs_a;
            r_cnt   <= '0;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial;
            r_q   <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift;
            r_q   <= {r_q[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_dz) begin
            r_quotient    <= '0;
            r_remainder   <= r_a;
            r_div_by_zero <= 1'b1;
            r_overflow    <= 1'b0;
          end else begin
            r_quotient    <= r_sign_q ? (~r_q + 1'b1) : r_q;
            r_remainder   <= r_sign_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
            r_div_by_zero <= 1'b0;
            r_overflow    <= !r_sign_q && (r_q == MIN_MAG);
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.done        = r_done;
  assign bus.busy        = r_busy;
  assign bus.div_by_zero = r_div_by_zero;
  assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_division_restoring_core.sv
// Self-checking bench for division_restoring_core: scoreboard of expected
// results built from integer division, compared when done pulses.
module tb_division_restoring_core;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  division_restoring_core_if #(.WIDTH(W)) bus ();

  division_restoring_core #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(int a, int b);
    exp_t e;
    int   q;
    int   r;
    if (b == 0) begin
      e.q = '0;
      e.r = a[W-1:0];
      e.dz = 1'b1;
      e.ov = 1'b0;
      e.lat = 2;
    end else begin
      q = a / b;
      r = a % b;
      e.q = q[W-1:0];
      e.r = r[W-1:0];
      e.dz = 1'b0;
      e.ov = (a == -(1 << (W-1))) && (b == -1);
      e.lat = W + 2;
    end
    return e;
  endfunction

  // Drive a one-cycle start pulse; returns #1 after the sampling edge E0.
  task automatic drive_start(input int a, input int b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.first_nr  = a[W-1:0];
    bus.second_nr = b[W-1:0];
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done is seen high; -1 on timeout.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.first_nr = '0;
    bus.second_nr = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_by_zero, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%b r=%b done=%b busy=%b dz=%b ov=%b, want all 0",
               bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_by_zero, bus.overflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int   edges;
    exp_t e;
    drive_start(7, 2);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_e0: got %b want 1", bus.busy);
    end
    wait_done(edges);
    e = sb.pop_front();
    checks++;
    if (edges !== e.lat) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges want %0d", edges, e.lat);
    end
    checks++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow, bus.busy} !== {e.q, e.r, e.dz, e.ov, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: got q=%b r=%b dz=%b ov=%b busy=%b want q=%b r=%b dz=%b ov=%b busy=0",
               bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow, bus.busy, e.q, e.r, e.dz, e.ov);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.done, bus.quotient, bus.remainder} !== {1'b0, e.q, e.r}) begin
      errors++;
      $display("FAIL basic_hold: got done=%b q=%b r=%b want done=0 q=%b r=%b",
               bus.done, bus.quotient, bus.remainder, e.q, e.r);
    end
  endtask

  // Signed cases, overflow corner, divide by zero and a few random operands.
  task automatic test_signed_table;
    int   ta[10];
    int   tb[10];
    int   edges;
    exp_t e;
    ta = '{-7,  7, -7, -8, -8, 5, 0, 0, 0, 0};
    tb = '{ 2, -2, -2, -1,  1, 0, 0, 0, 0, 0};
    for (int i = 6; i < 10; i++) begin
      ta[i] = int'($urandom_range(0, 15)) - 8;
      tb[i] = int'($urandom_range(0, 15)) - 8;
    end
    for (int i = 0; i < 10; i++) begin
      drive_start(ta[i], tb[i]);
      wait_done(edges);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL table_scoreboard_empty: got 0 entries want 1");
        continue;
      end
      e = sb.pop_front();
      checks++;
      if (edges !== e.lat) begin
        errors++;
        $display("FAIL table_latency %0d/%0d: got %0d want %0d", ta[i], tb[i], edges, e.lat);
      end
      checks++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== {e.q, e.r, e.dz, e.ov}) begin
        errors++;
        $display("FAIL table_result %0d/%0d: got q=%b r=%b dz=%b ov=%b want q=%b r=%b dz=%b ov=%b",
                 ta[i], tb[i], bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow,
                 e.q, e.r, e.dz, e.ov);
      end
    end
  endtask

  task automatic test_back_to_back;
    int   edges;
    exp_t e;
    drive_start(6, 3);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.first_nr = 4'b0001;
    bus.second_nr = 4'b0001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(edges);
    e = sb.pop_front();
    checks++;
    if (edges !== e.lat - 2) begin
      errors++;
      $display("FAIL busy_ignore_latency: got %0d want %0d", edges, e.lat - 2);
    end
    checks++;
    if ({bus.quotient, bus.remainder} !== {e.q, e.r}) begin
      errors++;
      $display("FAIL busy_ignore_result: got q=%b r=%b want q=%b r=%b",
               bus.quotient, bus.remainder, e.q, e.r);
    end
    // Start asserted during the done cycle must be accepted.
    drive_start(1, 1);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept_busy: got %b want 1", bus.busy);
    end
    wait_done(edges);
    e = sb.pop_front();
    checks++;
    if ({edges, bus.quotient, bus.remainder} !== {e.lat, e.q, e.r}) begin
      errors++;
      $display("FAIL b2b_result: got edges=%0d q=%b r=%b want edges=%0d q=%b r=%b",
               edges, bus.quotient, bus.remainder, e.lat, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid;
    int   edges;
    int   saw_done;
    exp_t e;
    drive_start(7, 2);
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_by_zero, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got q=%b r=%b done=%b busy=%b dz=%b ov=%b want all 0",
               bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_by_zero, bus.overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done++;
    end
    checks++;
    if (saw_done !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d done pulses want 0", saw_done);
    end
    drive_start(3, 2);
    wait_done(edges);
    e = sb.pop_front();
    checks++;
    if ({edges, bus.quotient, bus.remainder} !== {e.lat, e.q, e.r}) begin
      errors++;
      $display("FAIL reset_mid_recover: got edges=%0d q=%b r=%b want edges=%0d q=%b r=%b",
               edges, bus.quotient, bus.remainder, e.lat, e.q, e.r);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_signed_table();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/division_restoring_core.md
Name: division_restoring_core

Overview:
Sequential signed restoring divider for the calculator division path. It sits directly downstream of the operand two's-complement stage. It consumes that stage's first_nr (dividend) and second_nr (divisor) when the stage's finish flag is presented on start. It produces a truncating signed quotient and remainder with a single-cycle done pulse, plus divide-by-zero and overflow flags, for the result/display stage.

Parameters:
WIDTH, 4, operand/result width in bits (two's complement); internal magnitude registers are WIDTH bits, partial remainder WIDTH+1 bits.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  operand-valid strobe; driven by upstream complement finish flag
first_nr  input  WIDTH  dividend, signed two's complement
second_nr  input  WIDTH  divisor, signed two's complement
quotient  output  WIDTH  signed quotient, registered
remainder  output  WIDTH  signed remainder, registered
done  output  1  one-cycle pulse: quotient/remainder/flags valid
busy  output  1  high while an operation is in progress
div_by_zero  output  1  set with done when divisor was 0
overflow  output  1  set with done when the result is not representable

Behaviour:
- Reset (rst=1, async): state=IDLE. quotient, remainder, done, busy, div_by_zero and overflow all 0. Internal registers cleared.
- States: IDLE, LOAD, ITER, FIX.
- IDLE: when start=1 at an edge, capture first_nr/second_nr into operand registers, busy<=1, go to LOAD. While start=0, remain in IDLE.
- start is level-sampled only in IDLE; while busy=1 it is ignored and captured operands are never overwritten.
- LOAD (1 cycle):
  - Compute sign_q = dividend MSB XOR divisor MSB; sign_r = dividend MSB.
  - Compute unsigned magnitudes |a|, |b| in WIDTH bits; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - If divisor==0, go to FIX with dz flag set. Otherwise clear R (WIDTH+1 bits), load Q=|a|, iteration counter=0, go to ITER.
- ITER (exactly WIDTH cycles), each cycle:
  - {R,Q} <<= 1; trial = R - {0,|b|}.
  - If trial is non-negative: R<=trial and Q[0]<=1; else R unchanged and Q[0]<=0.
  - Counter increments; after the WIDTH-th iteration go to FIX.
- FIX (1 cycle), all outputs registered at this edge together with done<=1, busy<=0, next state IDLE:
  - Divide by zero: quotient<=0, remainder<=captured dividend, div_by_zero<=1, overflow<=0.
  - Otherwise: quotient<=sign_q ? -Q : Q; remainder<=sign_r ? -R[WIDTH-1:0] : R[WIDTH-1:0].
  - overflow<=1 only when sign_q=0 and Q=2^(WIDTH-1), i.e. (-2^(WIDTH-1))/(-1). In that case the quotient bit pattern is 2^(WIDTH-1) (1000 for WIDTH=4) and remainder is 0.
- done deasserts the following cycle. quotient, remainder, div_by_zero and overflow hold until the next FIX or reset.
- Latency, counting edges after the start-sampling edge E0:
  - Normal: done is high after edge E(WIDTH+2), i.e. 6 edges for WIDTH=4.
  - Divide by zero: done is high after edge E2.
- Back-to-back: start=1 in the done cycle is accepted, since state is IDLE.
- Division semantics: truncation toward zero. The remainder carries the dividend's sign, |remainder| < |divisor|, and dividend = q*divisor + r holds (modulo 2^WIDTH for the overflow case).
- Reset mid-operation: aborts immediately. No done pulse is produced and all outputs return to 0.

Test Plan:
- 7/2 (0111/0010), start pulse 1 cycle -> done after 6 edges; quotient=0011, remainder=0001; flags 0; busy high for edges E0..E5.
- -7/2 (1001/0010) -> quotient=1101 (-3), remainder=1111 (-1). Then 7/-2 -> quotient=1101, remainder=0001. Then -7/-2 -> quotient=0011, remainder=1111.
- -8/-1 (1000/1111) -> overflow=1, quotient=1000, remainder=0000, div_by_zero=0. Also -8/1 -> quotient=1000, overflow=0.
- 5/0 (0101/0000) -> done after 2 edges; div_by_zero=1, quotient=0000, remainder=0101.
- Start 6/3, then pulse start with operands 1/1 at E2 while busy -> ignored; result quotient=0010, remainder=0000. Start 1/1 asserted in the done cycle -> accepted, quotient=0001.
- Start 7/2, assert rst at E3 -> all outputs 0 immediately, no done pulse. After release, 3/2 -> quotient=0001, remainder=0001.
